ps2_device: RTL and testbench
=============================

# ps2_device

Open-collector PS/2 device-side endpoint (keyboard/mouse end of the link), driven from `sys_clk`. It generates the PS/2 clock and sends 11-bit device-to-host frames. It also detects host inhibit and request-to-send, then clocks in host-to-device frames and acknowledges them. It is used as a device emulator opposite the host controller, both in simulation benches and on boards that present a keyboard to an external host.

## Interface
- `HALF_PERIOD`, default 2000: `sys_clk` cycles per PS/2 clock half-period (40 µs at 50 MHz, 12.5 kHz). Must be ≥ 4.
- `IDLE_CYCLES`, default 2500: consecutive cycles both lines must read high before a TX may start (50 µs).
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  inout  1  open-collector; driven 0 or `z`.
- `ps2_data`  inout  1  open-collector; driven 0 or `z`.
- `tx_data`  in  8  byte to send; latched on acceptance.
- `send_req`  in  1  level request to send `tx_data`.
- `busy`  out  1  high from TX acceptance until `tx_done` or `tx_abort`.
- `tx_done`  out  1  one-cycle pulse when a TX frame completes.
- `tx_abort`  out  1  one-cycle pulse when the host inhibits a TX frame.
- `rx_data`  out  8  last received host byte; held.
- `ready`  out  1  one-cycle pulse when an RX frame completes.
- `error`  out  1  status of the last RX frame (parity or stop error); updated with `ready`, held.

## Operation
- Both lines pass through 2-FF synchronizers. All line decisions use the synchronized values (`clk_s`, `data_s`).
- The block drives a line only with 0. It releases with `z`.
- States:
  - IDLE: counts consecutive cycles with `clk_s & data_s`; the counter clears on any low.
  - From IDLE, `clk_s`=0 → INHIBIT. This has priority over `send_req`.
  - From IDLE, `send_req` with the idle count ≥ `IDLE_CYCLES` → TX. On entry, latch the frame: start 0, `tx_data[0..7]` LSB first, odd parity, stop 1. Assert `busy`.
  - TX: 11 bits. Each bit is a high phase followed by a low phase.
    - High phase: release clk, drive/release data per the bit, hold `HALF_PERIOD` cycles.
    - Low phase: drive clk 0 for `HALF_PERIOD` cycles.
    - Data changes only on the first cycle of a high phase.
    - After the 11th low phase, release both lines, pulse `tx_done`, drop `busy`, return to IDLE.
  - TX abort: on the last cycle of any high phase of bits 0–9, if `clk_s`=0 (host pulling), release both lines, pulse `tx_abort`, drop `busy`, go to INHIBIT. The frame is discarded and not retried.
  - INHIBIT: wait for `clk_s`=1. On that cycle, `data_s`=0 → RX (request-to-send); otherwise → IDLE.
  - RX:
    - Wait `HALF_PERIOD` cycles, then issue 11 clocks. Each clock is a low phase (drive clk 0, `HALF_PERIOD`) then a high phase (release, `HALF_PERIOD`).
    - Clocks 1–10: sample `data_s` on the 2nd cycle of each high phase, in order d0..d7, parity, stop.
    - If stop=1: drive data 0 for the whole of clock 11 (ack), then release it at the end of clock 11's high phase.
    - If stop=0: no ack is driven; clock 11 is still issued.
    - At the end of clock 11: `rx_data`←d7..d0, `error`←(parity not odd) | (stop=0), pulse `ready` for one cycle, return to IDLE.
  - RX abort: on the last cycle of any RX high phase, if `clk_s`=0, release both lines and go to INHIBIT. No `ready`; `rx_data` and `error` are unchanged.
- `send_req` is ignored outside IDLE. If it is still high after an abort or RX, it is re-evaluated in IDLE and needs a fresh idle window.

## Timing
- Reset values:
  - `busy`, `tx_done`, `tx_abort`, `ready`, `error` = 0; `rx_data` = 0.
  - Both lines released; state IDLE; idle counter 0.
- Reset mid-frame: lines are released on the next edge and no pulses are emitted.
- TX start: the start bit is driven (data 0) on the cycle after acceptance. Acceptance is 1 cycle after the idle count first reaches `IDLE_CYCLES` with `send_req` high.
- TX frame length: 22·`HALF_PERIOD` cycles. The first clk falling edge occurs `HALF_PERIOD` cycles after the start bit is driven.
- RX frame length: `HALF_PERIOD` + 22·`HALF_PERIOD` cycles from leaving INHIBIT to `ready`.
- Host-inhibit detection latency: at most one high phase plus 2 synchronizer cycles.
- Counters are sized to hold `max(HALF_PERIOD, IDLE_CYCLES)`. The idle counter saturates rather than wrapping.

## Test plan
- `tx_data`=0x1C, bus idle, `send_req` held → host model decodes 0x1C, parity 0, stop 1; `tx_done` is 1 cycle; `busy` is high for exactly 22·`HALF_PERIOD`+1 cycles.
- Host pulls clk low during the high phase of bit 4 of a 0xF0 send → `tx_abort` pulses; both lines released within `HALF_PERIOD`+2 cycles; no `tx_done`.
- Host inhibit 100 µs, then data low and release clk, sending 0xED with correct parity → device drives ack on clock 11; `ready` pulses; `rx_data`=0xED; `error`=0.
- Host sends 0xFF with even parity → `ready`, `rx_data`=0xFF, `error`=1. The next frame 0x00 with correct parity clears `error` to 0.
- `send_req` asserted while the host is inhibiting → no TX until clk has been released and both lines have been high for `IDLE_CYCLES`; then the byte is sent intact.
- `sys_rst` pulsed mid-RX at clock 6 → lines released; `ready`, `busy`, `rx_data`, `error` are all 0; the next host frame is received correctly.

Source files
------------

// File: rtl/ps2_device.sv
// PS/2 device-side endpoint: generates the PS/2 clock, sends device-to-host
// frames and receives/acknowledges host-to-device frames on open-collector lines.
`timescale 1ns/1ps
module ps2_device #(
    parameter int unsigned HALF_PERIOD = 2000,
    parameter int unsigned IDLE_CYCLES = 2500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    input  logic [7:0] tx_data,
    input  logic       send_req,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort,
    output logic [7:0] rx_data,
    output logic       ready,
    output logic       error
);

    localparam int unsigned CNT_MAX = (HALF_PERIOD > IDLE_CYCLES) ? HALF_PERIOD : IDLE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] IDLE_MIN = CW'(IDLE_CYCLES);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_TX_LOAD, S_TX_HI, S_TX_LO, S_RX_WAIT, S_RX_LO, S_RX_HI
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, idle_cnt, idle_cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [10:0]   tx_frame, tx_frame_n;
    logic [9:0]    rx_shift, rx_shift_n;
    logic          clk_oe, clk_oe_n, data_oe, data_oe_n;
    logic          busy_n, tx_done_n, tx_abort_n, ready_n, error_n;
    logic [7:0]    rx_data_n;
    logic          clk_meta, clk_s, data_meta, data_s;
    logic          phase_end;

    // Lines are only ever pulled low; release leaves them to the pull-ups.
    assign ps2_clk   = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data  = data_oe ? 1'b0 : 1'bz;
    assign phase_end = (cnt == HP_LAST);

    // Two-stage synchronizers for both lines
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    // State and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idle_cnt <= '0;
            bit_cnt  <= '0;
            tx_frame <= '0;
            rx_shift <= '0;
            clk_oe   <= 1'b0;
            data_oe  <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            rx_data  <= '0;
            ready    <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idle_cnt <= idle_cnt_n;
            bit_cnt  <= bit_cnt_n;
            tx_frame <= tx_frame_n;
            rx_shift <= rx_shift_n;
            clk_oe   <= clk_oe_n;
            data_oe  <= data_oe_n;
            busy     <= busy_n;
            tx_done  <= tx_done_n;
            tx_abort <= tx_abort_n;
            rx_data  <= rx_data_n;
            ready    <= ready_n;
            error    <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idle_cnt_n = idle_cnt;
        bit_cnt_n  = bit_cnt;
        tx_frame_n = tx_frame;
        rx_shift_n = rx_shift;
        clk_oe_n   = clk_oe;
        data_oe_n  = data_oe;
        busy_n     = busy;
        tx_done_n  = 1'b0;
        tx_abort_n = 1'b0;
        ready_n    = 1'b0;
        rx_data_n  = rx_data;
        error_n    = error;

        case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (clk_s && data_s)
                    idle_cnt_n = (idle_cnt == CNT_SAT) ? idle_cnt : idle_cnt + CW'(1);
                else
                    idle_cnt_n = '0;
                // Host inhibit wins over a pending send request
                if (!clk_s) begin
                    state_n = S_INHIBIT;
                end else if (send_req && idle_cnt >= IDLE_MIN) begin
                    state_n    = S_TX_LOAD;
                    busy_n     = 1'b1;
                    tx_frame_n = {1'b1, ~^tx_data, tx_data, 1'b0};
                end
            end

            S_TX_LOAD: begin
                state_n   = S_TX_HI;
                cnt_n     = '0;
                bit_cnt_n = '0;
                clk_oe_n  = 1'b0;
                data_oe_n = ~tx_frame[0];
            end

            S_TX_HI: begin
                cnt_n = cnt + CW'(1);
                if (phase_end) begin
                    cnt_n = '0;
                    if (bit_cnt != 4'd10 && !clk_s) begin
                        state_n    = S_INHIBIT;
                        clk_oe_n   = 1'b0;
                        data_oe_n  = 1'b0;
                        busy_n     = 1'b0;
                        tx_abort_n = 1'b1;
                        idle_cnt_n = '0;
                    end else begin
                        state_n  = S_TX_LO;
                        clk_oe_n = 1'b1;
                    end
                end
            end

            S_TX_LO: begin
                cnt_n = cnt + CW'(1);
                if (phase_end) begin
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                    if (bit_cnt == 4'd10) begin
                        state_n    = S_IDLE;
                        data_oe_n  = 1'b0;
                        busy_n     = 1'b0;
                        tx_done_n  = 1'b1;
                        idle_cnt_n = '0;
                    end else begin
                        state_n    = S_TX_HI;
                        bit_cnt_n  = bit_cnt + 4'd1;
                        tx_frame_n = {1'b0, tx_frame[10:1]};
                        data_oe_n  = ~tx_frame[1];
                    end
                end
            end

            S_INHIBIT: begin
                clk_oe_n   = 1'b0;
                data_oe_n  = 1'b0;
                idle_cnt_n = '0;
                if (clk_s) begin
                    if (!data_s) begin
                        state_n   = S_RX_WAIT;
                        cnt_n     = '0;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end

            S_RX_WAIT: begin
                cnt_n = cnt + CW'(1);
                if (phase_end) begin
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                    state_n  = S_RX_LO;
                end
            end

            S_RX_LO: begin
                cnt_n = cnt + CW'(1);
                if (phase_end) begin
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                    state_n  = S_RX_HI;
                end
            end

            S_RX_HI: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(1) && bit_cnt != 4'd10)
                    rx_shift_n = {data_s, rx_shift[9:1]};
                if (phase_end) begin
                    cnt_n = '0;
                    if (!clk_s) begin
                        state_n    = S_INHIBIT;
                        clk_oe_n   = 1'b0;
                        data_oe_n  = 1'b0;
                        idle_cnt_n = '0;
                    end else if (bit_cnt == 4'd10) begin
                        state_n    = S_IDLE;
                        data_oe_n  = 1'b0;
                        idle_cnt_n = '0;
                        ready_n    = 1'b1;
                        rx_data_n  = rx_shift[7:0];
                        error_n    = ~(^rx_shift[8:0]) | ~rx_shift[9];
                    end else begin
                        state_n   = S_RX_LO;
                        bit_cnt_n = bit_cnt + 4'd1;
                        clk_oe_n  = 1'b1;
                        // Ack the frame through clock 11 only when the stop bit was 1
                        if (bit_cnt == 4'd9)
                            data_oe_n = rx_shift[9];
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_device.sv
// Self-checking bench for ps2_device: host-side line model plus expected-value
// queues for device-to-host bytes and host-to-device results.
`timescale 1ns/1ps
module tb_ps2_device;

    localparam int unsigned HP = 8;
    localparam int unsigned IC = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] tx_data;
    logic       send_req;
    logic       busy, tx_done, tx_abort, ready, error;
    logic [7:0] rx_data;
    logic       host_clk_low, host_data_low;
    wire        ps2_clk, ps2_data;

    assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = host_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_device #(.HALF_PERIOD(HP), .IDLE_CYCLES(IC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .tx_data(tx_data), .send_req(send_req), .busy(busy), .tx_done(tx_done),
        .tx_abort(tx_abort), .rx_data(rx_data), .ready(ready), .error(error)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_tx_q[$];
    logic [8:0] exp_rx_q[$];

    // Pulse and run-length bookkeeping
    int busy_run = 0, last_busy_run = 0, done_cycles = 0, abort_cycles = 0, ready_cycles = 0;
    always @(negedge sys_clk) begin
        if (busy) busy_run <= busy_run + 1;
        else if (busy_run != 0) begin
            last_busy_run <= busy_run;
            busy_run      <= 0;
        end
        if (tx_done)  done_cycles  <= done_cycles + 1;
        if (tx_abort) abort_cycles <= abort_cycles + 1;
        if (ready)    ready_cycles <= ready_cycles + 1;
    end

    task automatic wait_clk(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (ps2_clk === val) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_busy(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (busy === val) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (ready === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Host decodes one device frame, sampling data on each clk falling edge
    task automatic host_receive(output logic [10:0] frame, output bit ok);
        bit k;
        frame = '0;
        ok    = 1'b1;
        for (int i = 0; i < 11; i++) begin
            wait_clk(1'b0, 4*HP, k);
            if (!k) begin ok = 1'b0; return; end
            frame[i] = ps2_data;
            wait_clk(1'b1, 4*HP, k);
            if (!k) begin ok = 1'b0; return; end
        end
    endtask

    // Host inhibit, request-to-send, then data bits; returns early at clock stop_at+1
    task automatic host_send(input logic [7:0] b, input logic par, input logic stop,
                             input int stop_at, output bit ok, output bit acked);
        bit k;
        logic [9:0] bits;
        bits  = {stop, par, b};
        ok    = 1'b1;
        acked = 1'b0;
        host_clk_low = 1'b1;
        repeat (5*HP) @(negedge sys_clk);
        host_data_low = 1'b1;
        repeat (HP) @(negedge sys_clk);
        host_clk_low = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_clk(1'b0, 4*HP, k);
            if (!k) begin ok = 1'b0; host_data_low = 1'b0; return; end
            if (i == stop_at) begin host_data_low = 1'b0; return; end
            if (i < 10) begin
                host_data_low = ~bits[i];
            end else begin
                host_data_low = 1'b0;
                @(negedge sys_clk);
                acked = (ps2_data === 1'b0);
            end
            wait_clk(1'b1, 4*HP, k);
            if (!k) begin ok = 1'b0; host_data_low = 1'b0; return; end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({busy, tx_done, tx_abort, ready, error} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 00000", {busy, tx_done, tx_abort, ready, error});
        end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
        checks++;
        if ({ps2_clk, ps2_data} !== 2'b11) begin
            errors++; $display("FAIL reset_lines: got %b required 11", {ps2_clk, ps2_data});
        end
    endtask

    task automatic test_tx_basic();
        bit ok;
        logic [10:0] fr;
        logic [7:0] exp;
        int d0;
        d0 = done_cycles;
        tx_data = 8'h1C;
        exp_tx_q.push_back(8'h1C);
        send_req = 1'b1;
        wait_busy(1'b1, IC + 4*HP, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_accept: busy=0 required 1"); end
        send_req = 1'b0;
        host_receive(fr, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_frame_timeout: got incomplete frame required 11 bits"); end
        exp = exp_tx_q.pop_front();
        checks++;
        if (fr[8:1] !== exp) begin errors++; $display("FAIL tx_data: got %h required %h", fr[8:1], exp); end
        checks++;
        if ({fr[10], fr[9], fr[0]} !== 3'b100) begin
            errors++; $display("FAIL tx_framing: stop/parity/start got %b required 100", {fr[10], fr[9], fr[0]});
        end
        wait_busy(1'b0, 4*HP, ok);
        repeat (3) @(negedge sys_clk);
        checks++;
        if (last_busy_run != 22*HP + 1) begin
            errors++; $display("FAIL tx_busy_len: got %0d required %0d", last_busy_run, 22*HP + 1);
        end
        checks++;
        if (done_cycles - d0 != 1) begin errors++; $display("FAIL tx_done_width: got %0d required 1", done_cycles - d0); end
    endtask

    task automatic test_tx_abort();
        bit ok, k;
        int a0, d0, n;
        a0 = abort_cycles;
        d0 = done_cycles;
        tx_data  = 8'hF0;
        send_req = 1'b1;
        wait_busy(1'b1, IC + 4*HP, ok);
        send_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clk(1'b0, 4*HP, k); ok &= k;
            wait_clk(1'b1, 4*HP, k); ok &= k;
        end
        repeat (2) @(negedge sys_clk);
        checks++;
        if (!ok || ps2_data !== 1'b0) begin
            errors++; $display("FAIL abort_bit4_data: ok=%0d data=%b required ok=1 data=0", ok, ps2_data);
        end
        host_clk_low = 1'b1;
        n = 0;
        while (ps2_data !== 1'b1 && n < HP + 2) begin @(negedge sys_clk); n++; end
        checks++;
        if (ps2_data !== 1'b1) begin errors++; $display("FAIL abort_release: data=%b after %0d cycles required 1", ps2_data, n); end
        repeat (3) @(negedge sys_clk);
        checks++;
        if (abort_cycles - a0 != 1 || done_cycles - d0 != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_pulses: abort=%0d done=%0d busy=%b required 1 0 0",
                               abort_cycles - a0, done_cycles - d0, busy);
        end
        host_clk_low = 1'b0;
        repeat (4) @(negedge sys_clk);
        checks++;
        if (ps2_clk !== 1'b1) begin errors++; $display("FAIL abort_clk_release: got %b required 1", ps2_clk); end
        repeat (2*IC) @(negedge sys_clk);
    endtask

    task automatic test_rx_ok();
        bit ok, acked;
        logic [8:0] e;
        exp_rx_q.push_back({1'b0, 8'hED});
        host_send(8'hED, ~^8'hED, 1'b1, 99, ok, acked);
        checks++;
        if (!ok || !acked) begin errors++; $display("FAIL rx_ok_ack: ok=%0d ack=%0d required 1 1", ok, acked); end
        wait_ready(4*HP, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_ok_ready: ready=0 required 1"); end
        e = exp_rx_q.pop_front();
        checks++;
        if ({error, rx_data} !== e) begin errors++; $display("FAIL rx_ok_result: got %b_%h required %b_%h", error, rx_data, e[8], e[7:0]); end
        @(negedge sys_clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rx_ok_ready_width: got %b required 0", ready); end
        repeat (2*IC) @(negedge sys_clk);
    endtask

    task automatic test_rx_error();
        bit ok, acked;
        logic [8:0] e;
        logic [7:0] bytes [3] = '{8'hFF, 8'h00, 8'h55};
        logic       pars  [3] = '{1'b0, 1'b1, 1'b1};
        logic       stops [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            exp_rx_q.push_back({~(^{pars[i], bytes[i]}) | ~stops[i], bytes[i]});
            host_send(bytes[i], pars[i], stops[i], 99, ok, acked);
            checks++;
            if (!ok || acked !== stops[i]) begin
                errors++; $display("FAIL rx_err_ack[%0d]: ok=%0d ack=%0d required 1 %0d", i, ok, acked, stops[i]);
            end
            wait_ready(4*HP, ok);
            e = exp_rx_q.pop_front();
            checks++;
            if (!ok || {error, rx_data} !== e) begin
                errors++; $display("FAIL rx_err_result[%0d]: ready=%0d got %b_%h required %b_%h", i, ok, error, rx_data, e[8], e[7:0]);
            end
            repeat (2*IC) @(negedge sys_clk);
        end
    endtask

    task automatic test_reset_mid_rx();
        bit ok, acked;
        logic [8:0] e;
        int r0;
        r0 = ready_cycles;
        host_send(8'h3C, ~^8'h3C, 1'b1, 5, ok, acked);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (!ok || {ps2_clk, ps2_data} !== 2'b11) begin
            errors++; $display("FAIL rst_rx_lines: ok=%0d got %b required 11", ok, {ps2_clk, ps2_data});
        end
        checks++;
        if ({ready, busy, error} !== 3'b000 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_rx_outputs: got %b_%h required 000_00", {ready, busy, error}, rx_data);
        end
        repeat (4*HP) @(negedge sys_clk);
        checks++;
        if (ready_cycles != r0) begin errors++; $display("FAIL rst_rx_no_ready: got %0d required 0", ready_cycles - r0); end
        exp_rx_q.push_back({1'b0, 8'h96});
        host_send(8'h96, ~^8'h96, 1'b1, 99, ok, acked);
        wait_ready(4*HP, ok);
        e = exp_rx_q.pop_front();
        checks++;
        if (!ok || !acked || {error, rx_data} !== e) begin
            errors++; $display("FAIL rst_rx_next: ready=%0d ack=%0d got %b_%h required %b_%h", ok, acked, error, rx_data, e[8], e[7:0]);
        end
        repeat (2*IC) @(negedge sys_clk);
    endtask

    task automatic test_inhibit_send();
        bit ok, seen;
        logic [10:0] fr;
        logic [7:0] exp;
        int n;
        host_clk_low = 1'b1;
        repeat (3) @(negedge sys_clk);
        tx_data  = 8'hA5;
        send_req = 1'b1;
        exp_tx_q.push_back(8'hA5);
        seen = 1'b0;
        repeat (5*HP) begin @(negedge sys_clk); if (busy) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL inhibit_no_tx: busy=1 required 0"); end
        host_clk_low = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < IC + 20) begin @(negedge sys_clk); n++; end
        checks++;
        if (busy !== 1'b1 || n < IC) begin
            errors++; $display("FAIL inhibit_window: busy=%b after %0d cycles required 1 after >=%0d", busy, n, IC);
        end
        send_req = 1'b0;
        host_receive(fr, ok);
        exp = exp_tx_q.pop_front();
        checks++;
        if (!ok || fr !== {1'b1, ~^exp, exp, 1'b0}) begin
            errors++; $display("FAIL inhibit_frame: ok=%0d got %b required %b", ok, fr, {1'b1, ~^exp, exp, 1'b0});
        end
        wait_busy(1'b0, 4*HP, ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [10:0] fr;
        logic [7:0] exp;
        int n;
        repeat (2*IC) @(negedge sys_clk);
        tx_data = 8'h5A;
        exp_tx_q.push_back(8'h5A);
        exp_tx_q.push_back(8'h3C);
        send_req = 1'b1;
        wait_busy(1'b1, IC + 4*HP, ok);
        tx_data = 8'h3C;
        host_receive(fr, ok);
        exp = exp_tx_q.pop_front();
        checks++;
        if (!ok || fr !== {1'b1, ~^exp, exp, 1'b0}) begin
            errors++; $display("FAIL b2b_first: ok=%0d got %b required %b", ok, fr, {1'b1, ~^exp, exp, 1'b0});
        end
        wait_busy(1'b0, 4*HP, ok);
        n = 0;
        while (busy !== 1'b1 && n < IC + 20) begin @(negedge sys_clk); n++; end
        checks++;
        if (busy !== 1'b1 || n < IC) begin
            errors++; $display("FAIL b2b_gap: busy=%b after %0d cycles required 1 after >=%0d", busy, n, IC);
        end
        send_req = 1'b0;
        host_receive(fr, ok);
        exp = exp_tx_q.pop_front();
        checks++;
        if (!ok || fr !== {1'b1, ~^exp, exp, 1'b0}) begin
            errors++; $display("FAIL b2b_second: ok=%0d got %b required %b", ok, fr, {1'b1, ~^exp, exp, 1'b0});
        end
        wait_busy(1'b0, 4*HP, ok);
    endtask

    initial begin
        sys_rst       = 1'b1;
        send_req      = 1'b0;
        tx_data       = 8'h00;
        host_clk_low  = 1'b0;
        host_data_low = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_abort();
        test_rx_ok();
        test_rx_error();
        test_reset_mid_rx();
        test_inhibit_send();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
